dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the pipeline's MEM-stage load/store interface. Accepts one word request at a time from the CPU (MemRead/MemWrite, address, store data), holds it for a programmable number of wait cycles, then returns a one-cycle response with load data or an error flag. Asserts busy_o while a request is outstanding so the CPU can stall its pipeline.

## Interface
- DEPTH, 128: number of 32-bit words stored; power of two, 16..1024.
- LATENCY, 2: wait cycles between acceptance and response; 0..15.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present; MemRead_i, MemWrite_i, addr_i and data_i are valid.
- req_ready_o  out  1  responder can accept; high only in IDLE.
- MemRead_i  in  1  load request.
- MemWrite_i  in  1  store request.
- addr_i  in  32  byte address.
- data_i  in  32  store data.
- rsp_valid_o  out  1  one-cycle response pulse.
- data_o  out  32  load data; valid only with rsp_valid_o, else 0.
- err_o  out  1  request rejected; valid only with rsp_valid_o, else 0.
- busy_o  out  1  request outstanding (state != IDLE).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. Accept when req_valid_i=1 on a rising edge. Latch op, addr and data, and classify:
  - err if addr_i[1:0] != 0.
  - err if addr_i[31:2] >= DEPTH.
  - err if MemRead_i and MemWrite_i are both high.
  - nop if neither flag is set.
- IDLE transition: go to WAIT when LATENCY > 0 and load counter with LATENCY-1; go to RESP when LATENCY = 0.
- WAIT: counter decrements each cycle. At 0, go to RESP. Input changes are ignored.
- RESP, for one cycle: rsp_valid_o=1, then go to IDLE.
  - Read: data_o = mem[addr[31:2]].
  - Write: commit data to mem on the edge leaving RESP.
  - err: no write; data_o=0.
  - nop: data_o=0, err_o=0.
- No response backpressure. The CPU must consume the pulse.
- Error on an out-of-range address is reported, never wrapped.

## Timing
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - rsp_valid_o=0, data_o=0, err_o=0, busy_o=0, req_ready_o=0 while rst_i=0 and 1 after release.
  - Memory array cleared to 0.
  - Counter cleared.
- Request accepted on edge k: busy_o high from edge k through edge k+LATENCY+1; rsp_valid_o high in the cycle after edge k+LATENCY.
- Next request acceptable on edge k+LATENCY+2, i.e. one request per LATENCY+2 cycles.
- Store committed on edge k+LATENCY+1. A load accepted afterward returns the new value.
- req_valid_i held high continuously: accepted again on the first edge in IDLE, with no bubble beyond the RESP cycle.
- Reset during WAIT or RESP: the request is dropped, no store is committed and no response is emitted.

## Structure
- Package dmem_pkg: state enum (IDLE, WAIT, RESP), op encoding (NOP, RD, WR, ERR), 4-bit counter width constant.
- Sub-module dmem_array: DEPTH x 32 storage with combinational read, synchronous write enable and asynchronous active-low clear.
- Top level contains the FSM, the request latch, the classifier and the counter.

## Test plan
- LATENCY=2: store 0xDEADBEEF to addr 0x10 accepted at edge 5 → rsp_valid_o high in cycle after edge 7, err_o=0. Then load 0x10 → data_o=0xDEADBEEF.
- Load from 0x13 → err_o=1, data_o=0, memory unchanged. Load from addr DEPTH*4 → err_o=1.
- MemRead_i=MemWrite_i=1 at 0x20 → err_o=1, no write (subsequent load 0x20 returns 0). Neither flag set → rsp with err_o=0, data_o=0.
- LATENCY=0: back-to-back loads with req_valid_i held high → accepted every 2nd edge, rsp_valid_o alternates 1/0, busy_o toggles.
- rst_i pulled low during WAIT of a store to 0x40 → no rsp_valid_o, all outputs 0. After release, load 0x40 returns 0.
- Sweep LATENCY 0..15: measured acceptance-to-response = LATENCY+1 edges in every case.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, request op
// classes, wait counter width and the request classifier.
package dmem_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        NOP,
        RD,
        WR,
        ERR
    } op_t;

    // Alignment and range faults take priority over the op flags.
    function automatic op_t classify(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input int unsigned depth
    );
        op_t op;
        op = NOP;
        if (addr[1:0] != 2'b00) begin
            op = ERR;
        end else if ({2'b00, addr[31:2]} >= 32'(depth)) begin
            op = ERR;
        end else if (rd && wr) begin
            op = ERR;
        end else if (rd) begin
            op = RD;
        end else if (wr) begin
            op = WR;
        end
        return op;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: combinational read, synchronous write.
// Ports: clk_i, rst_i (async clear, active low), we_i, addr_i, wdata_i, rdata_o.
module dmem_array #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, waits
// LATENCY cycles, then pulses a one-cycle response (load data or error).
// Ports: clk_i, rst_i (async, active low); request req_valid_i/req_ready_o,
// MemRead_i, MemWrite_i, addr_i, data_i; response rsp_valid_o, data_o,
// err_o; busy_o while a request is outstanding.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        rsp_valid_o,
    output logic [31:0] data_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op_q, op_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdata;
    logic             mem_we;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= NOP;
            idx_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d   = classify(MemRead_i, MemWrite_i,
                                      addr_i, DEPTH);
                    idx_d  = addr_i[AW+1:2];
                    wdat_d = data_i;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Store lands on the edge that leaves RESP.
    assign mem_we = (state_q == RESP) && (op_q == WR);

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .addr_i  (idx_q),
        .wdata_i (wdat_q),
        .rdata_o (rdata)
    );

    // Gate ready with reset so it stays low while reset is held.
    assign req_ready_o = rst_i && (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign err_o       = rsp_valid_o && (op_q == ERR);
    assign data_o      = (rsp_valid_o && (op_q == RD)) ? rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized check of dmem_responder against a word-array reference model,
// plus a LATENCY 0..15 sweep and back-to-back LATENCY=0 traffic.
module tb_dmem_responder;

    localparam int DEPTH = 128;
    localparam int LAT   = 2;
    localparam int SW_N  = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp;
    logic [31:0] dout;
    logic        err;
    logic        busy;

    logic             sw_valid;
    logic             sw_rd;
    logic             sw_wr;
    logic [31:0]      sw_addr;
    logic [31:0]      sw_wdata;
    logic [SW_N-1:0]  sw_ready;
    logic [SW_N-1:0]  sw_rsp;
    logic [SW_N-1:0]  sw_err;
    logic [SW_N-1:0]  sw_busy;
    logic [31:0]      sw_dout [SW_N];

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (ready),
        .MemRead_i   (rd),
        .MemWrite_i  (wr),
        .addr_i      (addr),
        .data_i      (wdata),
        .rsp_valid_o (rsp),
        .data_o      (dout),
        .err_o       (err),
        .busy_o      (busy)
    );

    for (genvar g = 0; g < SW_N; g++) begin : g_sw
        dmem_responder #(
            .DEPTH   (16),
            .LATENCY (g)
        ) u_sw (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .req_valid_i (sw_valid),
            .req_ready_o (sw_ready[g]),
            .MemRead_i   (sw_rd),
            .MemWrite_i  (sw_wr),
            .addr_i      (sw_addr),
            .data_i      (sw_wdata),
            .rsp_valid_o (sw_rsp[g]),
            .data_o      (sw_dout[g]),
            .err_o       (sw_err[g]),
            .busy_o      (sw_busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // One request on the main DUT, checked end to end.
    task automatic do_req(input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        logic        e_err;
        logic [31:0] e_dat;
        int          n;
        int          wi;
        wi    = int'(a >> 2);
        e_err = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH)) || (r && w);
        e_dat = (!e_err && r) ? ref_mem[wi] : 32'h0;
        @(negedge clk);
        chk("ready_idle", 32'(ready), 32'd1);
        req_valid = 1'b1;
        rd        = r;
        wr        = w;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rd        = 1'($urandom);
        wr        = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        n = 0;
        while (!rsp && n < 40) begin
            chk("busy_wait", 32'(busy), 32'd1);
            chk("dout_quiet", dout, 32'h0);
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("busy_rsp", 32'(busy), 32'd1);
        chk("err", 32'(err), 32'(e_err));
        chk("rdata", dout, e_dat);
        if (!e_err && w) ref_mem[wi] = d;
        @(negedge clk);
        chk("rsp_drop", 32'(rsp), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic rand_req();
        logic [31:0] a;
        logic        r;
        logic        w;
        int          sel;
        int          k;
        sel = $urandom_range(0, 9);
        if (sel <= 5) begin
            a = 32'($urandom_range(0, 31)) << 2;
        end else if (sel == 6) begin
            a = (32'($urandom_range(0, DEPTH - 1)) << 2)
                | 32'($urandom_range(1, 3));
        end else if (sel == 7) begin
            a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) << 2);
        end else begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        end
        k = $urandom_range(0, 3);
        r = (k == 0) || (k == 2);
        w = (k == 1) || (k == 2);
        if (k == 3) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        do_req(r, w, a, $urandom);
    endtask

    task automatic sweep();
        int          lat [SW_N];
        logic [31:0] got [SW_N];
        logic [31:0] val;
        val = $urandom;
        @(negedge clk);
        chk("sw_ready", 32'(sw_ready), 32'h0000_FFFF);
        sw_valid = 1'b1;
        sw_rd    = 1'b0;
        sw_wr    = 1'b1;
        sw_addr  = 32'h4;
        sw_wdata = val;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        for (int g = 0; g < SW_N; g++) lat[g] = -1;
        for (int c = 0; c < 20; c++) begin
            for (int g = 0; g < SW_N; g++) begin
                if (sw_rsp[g] && lat[g] < 0) lat[g] = c + 1;
            end
            @(negedge clk);
        end
        for (int g = 0; g < SW_N; g++) begin
            chk($sformatf("sw_lat%0d", g), 32'(lat[g]), 32'(g + 1));
        end
        chk("sw_busy_idle", 32'(sw_busy), 32'h0);
        sw_valid = 1'b1;
        sw_rd    = 1'b1;
        sw_wr    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        for (int g = 0; g < SW_N; g++) got[g] = 32'hFFFF_FFFF;
        for (int c = 0; c < 20; c++) begin
            for (int g = 0; g < SW_N; g++) begin
                if (sw_rsp[g]) begin
                    got[g] = sw_dout[g];
                    chk($sformatf("sw_err%0d", g), 32'(sw_err[g]), 32'd0);
                end
            end
            @(negedge clk);
        end
        for (int g = 0; g < SW_N; g++) begin
            chk($sformatf("sw_load%0d", g), got[g], val);
        end
        // LATENCY=0 with valid held high: one accept every second edge.
        sw_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("b2b_rsp", 32'(sw_rsp[0]), 32'(j % 2 == 0));
            chk("b2b_busy", 32'(sw_busy[0]), 32'(j % 2 == 0));
            chk("b2b_data", sw_dout[0], (j % 2 == 0) ? val : 32'h0);
        end
        sw_valid = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        addr      = '0;
        wdata     = '0;
        sw_valid  = 1'b0;
        sw_rd     = 1'b0;
        sw_wr     = 1'b0;
        sw_addr   = '0;
        sw_wdata  = '0;
        model_clear();
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp", 32'(rsp), 32'd0);
        chk("rst_data", dout, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(ready), 32'd1);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 1'b0, 32'h13, 32'h0);
        do_req(1'b1, 1'b0, 32'(DEPTH * 4), 32'h0);
        do_req(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < 150; i++) rand_req();

        // Reset while a store sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1;
        rd        = 1'b0;
        wr        = 1'b1;
        addr      = 32'h40;
        wdata     = 32'hA5A5_5A5A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp", 32'(rsp), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_data", dout, 32'h0);
        chk("mid_rst_err", 32'(err), 32'd0);
        model_clear();
        repeat (3) begin
            @(negedge clk);
            chk("held_rst_rsp", 32'(rsp), 32'd0);
        end
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 32'h40, 32'h0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < 60; i++) rand_req();

        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
